// File: rtl/can_tx_priority_pkg.sv
// ---------------------------------------------------------------------------
// can_pkg
//   Shared CAN transmit-path definitions: field widths, the frame record that
//   moves between the host queue and the TX engine, and the per-cycle
//   operation decode used by the priority queue.
//
//   ID_W       standard identifier width (11 bits)
//   DLC_W      data length code width (4 bits)
//   MAX_BYTES  payload bytes carried per frame (always 8 stored)
// ---------------------------------------------------------------------------
package can_pkg;

  localparam int ID_W      = 11;
  localparam int DLC_W     = 4;
  localparam int MAX_BYTES = 8;

  // data[i] is payload byte i; all eight bytes travel with the frame whatever the DLC.
  typedef struct packed {
    logic [ID_W-1:0]            id;
    logic [DLC_W-1:0]           dlc;
    logic [MAX_BYTES-1:0][7:0]  data;
  } can_frame_t;

  // Encoding matches {we, re} so the decode is a plain cast.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } op_e;

  function automatic can_frame_t make_frame(
    input logic [ID_W-1:0]           id,
    input logic [DLC_W-1:0]          dlc,
    input logic [MAX_BYTES-1:0][7:0] data
  );
    can_frame_t f;
    f.id   = id;
    f.dlc  = dlc;
    f.data = data;
    return f;
  endfunction

endpackage

// File: rtl/can_tx_priority_if.sv
// ---------------------------------------------------------------------------
// can_tx_priority_if
//   Bundle between the host write side / TX engine and the priority queue.
//
//   we, re              write strobe and head acknowledge
//   req_id/dlc/data     frame being written
//   tx_id/dlc/data      registered head frame
//   start_tx            head frame valid
//   full, empty         occupancy flags
//
//   master : the host / TX engine side (drives strobes and request frame)
//   slave  : the queue itself
// ---------------------------------------------------------------------------
interface can_tx_priority_if;
  import can_pkg::*;

  logic                           we;
  logic                           re;
  logic [ID_W-1:0]                req_id;
  logic [DLC_W-1:0]               req_dlc;
  logic [MAX_BYTES-1:0][7:0]      req_data;

  logic [ID_W-1:0]                tx_id;
  logic [DLC_W-1:0]               tx_dlc;
  logic [MAX_BYTES-1:0][7:0]      tx_data;
  logic                           start_tx;
  logic                           full;
  logic                           empty;

  modport master (
    output we, re, req_id, req_dlc, req_data,
    input  tx_id, tx_dlc, tx_data, start_tx, full, empty
  );

  modport slave (
    input  we, re, req_id, req_dlc, req_data,
    output tx_id, tx_dlc, tx_data, start_tx, full, empty
  );

endinterface

// File: rtl/can_tx_priority_insert.sv
// ---------------------------------------------------------------------------
// can_tx_priority_insert
//   Combinational sorted insert of one frame into an N-slot array kept in
//   ascending ID order with valid slots packed from index 0.
//
//   frame         frame to insert
//   before_equal  1: insert ahead of slots with an equal ID
//                 0: insert behind them (FIFO among equal IDs)
//   slots_in      current slot contents, valid_in their valid bits
//   slots_out     array after insertion, valid_out its valid bits
//   ok            a free slot exists, so nothing falls off the end
// ---------------------------------------------------------------------------
module can_tx_priority_insert
  import can_pkg::*;
#(
  parameter int N = 4
) (
  input  can_frame_t    frame,
  input  logic          before_equal,
  input  can_frame_t    slots_in  [N],
  input  logic [N-1:0]  valid_in,
  output can_frame_t    slots_out [N],
  output logic [N-1:0]  valid_out,
  output logic          ok
);

  logic [N-1:0] take;
  logic [N-1:0] passed;
  logic [N-1:0] prev_valid;
  logic         seen;
  can_frame_t   prev [N];

  // A slot can take the new frame if it is free or holds a later-ordered ID.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      take[i] = !valid_in[i] ||
                (before_equal ? (slots_in[i].id >= frame.id)
                              : (slots_in[i].id >  frame.id));
    end
  end

  // passed[i] is set once the insertion point lies strictly below slot i,
  // meaning slot i receives its lower neighbour (shift up by one).
  always_comb begin
    seen   = 1'b0;
    passed = '0;
    for (int i = 0; i < N; i++) begin
      passed[i] = seen;
      seen      = seen | take[i];
    end
  end

  // Lower neighbour of each slot; slot 0 has none and never shifts.
  always_comb begin
    prev[0] = frame;
    for (int i = 1; i < N; i++) begin
      prev[i] = slots_in[i-1];
    end
  end

  assign prev_valid = {valid_in[N-2:0], 1'b1};

  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (passed[i]) begin
        slots_out[i] = prev[i];
        valid_out[i] = prev_valid[i];
      end else if (take[i]) begin
        slots_out[i] = frame;
        valid_out[i] = 1'b1;
      end else begin
        slots_out[i] = slots_in[i];
        valid_out[i] = valid_in[i];
      end
    end
  end

  assign ok = !valid_in[N-1];

endmodule

// File: rtl/can_tx_priority.sv
// ---------------------------------------------------------------------------
// can_tx_priority
//   Priority-ordered CAN transmit queue. The lowest identifier held is always
//   presented in the registered head (tx_*); up to N more frames wait in an
//   ID-sorted buffer. Equal IDs leave in arrival order.
//
//   clk   system clock, all updates on the rising edge
//   rst   synchronous active-low reset
//   bus   can_tx_priority_if.slave:
//           we/re + req_* in, tx_* / start_tx / full / empty out
//
//   Each edge applies an optional pop of the head followed by an optional
//   write to the resulting set, so a write alongside a read is accepted even
//   when the queue is full.
// ---------------------------------------------------------------------------
module can_tx_priority
  import can_pkg::*;
#(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst,
  can_tx_priority_if.slave  bus
);

  localparam int            CW  = $clog2(N + 2);
  localparam logic [CW-1:0] CAP = CW'(N + 1);

  op_e          op;
  logic         rd_en;
  logic         wr_en;
  logic         do_pop;
  logic         preempt;
  logic         accept;
  logic         ins_ok;

  can_frame_t   req_frame;
  can_frame_t   ins_frame;

  can_frame_t   head_q, head_p, head_d;
  logic         head_valid_q, head_valid_p, head_valid_d;

  can_frame_t   slots_q [N];
  can_frame_t   slots_p [N];
  can_frame_t   slots_d [N];
  can_frame_t   ins_slots [N];
  logic [N-1:0] valid_q, valid_p, valid_d, ins_valid;

  logic [CW-1:0] count_q, count_p, count_d;

  assign op        = op_e'({bus.we, bus.re});
  assign rd_en     = (op == OP_READ)  || (op == OP_BOTH);
  assign wr_en     = (op == OP_WRITE) || (op == OP_BOTH);
  assign do_pop    = rd_en && (count_q != '0);
  assign req_frame = make_frame(bus.req_id, bus.req_dlc, bus.req_data);

  // Pop stage: head takes buffer[0] and the buffer shifts down. When the
  // buffer was empty the head goes invalid but keeps its old fields, so the
  // tx_* outputs hold their last value.
  always_comb begin
    head_p       = head_q;
    head_valid_p = head_valid_q;
    slots_p      = slots_q;
    valid_p      = valid_q;
    count_p      = count_q;
    if (do_pop) begin
      head_valid_p = valid_q[0];
      if (valid_q[0]) begin
        head_p = slots_q[0];
      end
      for (int i = 0; i < N - 1; i++) begin
        slots_p[i] = slots_q[i+1];
      end
      valid_p = {1'b0, valid_q[N-1:1]};
      count_p = count_q - CW'(1);
    end
  end

  // A strictly lower ID displaces the head. The displaced head is the
  // oldest of the lowest IDs held, so it goes back ahead of any equals.
  assign preempt   = head_valid_p && (req_frame.id < head_p.id);
  assign ins_frame = preempt ? head_p : req_frame;

  can_tx_priority_insert #(.N(N)) u_insert (
    .frame        (ins_frame),
    .before_equal (preempt),
    .slots_in     (slots_p),
    .valid_in     (valid_p),
    .slots_out    (ins_slots),
    .valid_out    (ins_valid),
    .ok           (ins_ok)
  );

  // With a valid head there is room exactly when the buffer's last slot is
  // free; with no head the buffer is empty and the frame goes straight in.
  assign accept = wr_en && (!head_valid_p || ins_ok);

  // Write stage applied on top of the post-pop state.
  always_comb begin
    head_d       = head_p;
    head_valid_d = head_valid_p;
    slots_d      = slots_p;
    valid_d      = valid_p;
    count_d      = count_p;
    if (accept) begin
      count_d = count_p + CW'(1);
      if (!head_valid_p) begin
        head_d       = req_frame;
        head_valid_d = 1'b1;
      end else begin
        slots_d = ins_slots;
        valid_d = ins_valid;
        if (preempt) begin
          head_d = req_frame;
        end
      end
    end
  end

  // Control state and head register; reset clears the visible head fields.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q       <= '0;
      head_valid_q <= 1'b0;
      valid_q      <= '0;
      count_q      <= '0;
    end else begin
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
    end
  end

  // Buffer payload needs no reset; its valid bits gate every use.
  always_ff @(posedge clk) begin
    slots_q <= slots_d;
  end

  assign bus.tx_id    = head_q.id;
  assign bus.tx_dlc   = head_q.dlc;
  assign bus.tx_data  = head_q.data;
  assign bus.start_tx = head_valid_q;
  assign bus.full     = (count_q == CAP);
  assign bus.empty    = (count_q == '0);

endmodule

// File: tb/tb_can_tx_priority.sv
// ---------------------------------------------------------------------------
// tb_can_tx_priority
//   Self-checking bench for can_tx_priority. The reference model is a plain
//   queue of frames in arrival order: the head is the earliest frame with the
//   lowest ID, a pop removes it, a write appends while fewer than N+1 frames
//   are held, and tx_* show the most recent head.
// ---------------------------------------------------------------------------
module tb_can_tx_priority;
  import can_pkg::*;

  localparam int N   = 4;
  localparam int CAP = N + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;

  can_tx_priority_if bus ();

  can_tx_priority #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference state
  can_frame_t model_q[$];
  can_frame_t last_tx;

  // Earliest entry among those with the lowest ID.
  function automatic int headIdx();
    int best = 0;
    for (int i = 1; i < model_q.size(); i++) begin
      if (model_q[i].id < model_q[best].id) best = i;
    end
    return best;
  endfunction

  task automatic modelStep(input logic w, input logic r, input can_frame_t f);
    if (r && model_q.size() > 0) model_q.delete(headIdx());
    if (w && model_q.size() < CAP) model_q.push_back(f);
    if (model_q.size() > 0) last_tx = model_q[headIdx()];
  endtask

  task automatic checkOutput(input string tag);
    logic exp_valid, exp_full, exp_empty;
    exp_valid = (model_q.size() > 0);
    exp_full  = (model_q.size() == CAP);
    exp_empty = (model_q.size() == 0);
    checks++;
    assert (bus.tx_id === last_tx.id) else begin
      errors++;
      $error("[TB] FAIL %s tx_id: observed %h expected %h", tag, bus.tx_id, last_tx.id);
    end
    checks++;
    assert (bus.tx_dlc === last_tx.dlc) else begin
      errors++;
      $error("[TB] FAIL %s tx_dlc: observed %h expected %h", tag, bus.tx_dlc, last_tx.dlc);
    end
    checks++;
    assert (bus.tx_data === last_tx.data) else begin
      errors++;
      $error("[TB] FAIL %s tx_data: observed %h expected %h", tag, bus.tx_data, last_tx.data);
    end
    checks++;
    assert (bus.start_tx === exp_valid) else begin
      errors++;
      $error("[TB] FAIL %s start_tx: observed %b expected %b", tag, bus.start_tx, exp_valid);
    end
    checks++;
    assert (bus.full === exp_full) else begin
      errors++;
      $error("[TB] FAIL %s full: observed %b expected %b", tag, bus.full, exp_full);
    end
    checks++;
    assert (bus.empty === exp_empty) else begin
      errors++;
      $error("[TB] FAIL %s empty: observed %b expected %b", tag, bus.empty, exp_empty);
    end
  endtask

  // Fixed expectations for the directed scenarios, independent of the model.
  task automatic expectId(input string tag, input logic [10:0] exp);
    checks++;
    assert (bus.tx_id === exp) else begin
      errors++;
      $error("[TB] FAIL %s tx_id: observed %h expected %h", tag, bus.tx_id, exp);
    end
  endtask

  task automatic expectBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check #1 later.
  task automatic applyStimulus(input logic w, input logic r, input can_frame_t f,
                               input string tag);
    bus.we       = w;
    bus.re       = r;
    bus.req_id   = f.id;
    bus.req_dlc  = f.dlc;
    bus.req_data = f.data;
    @(posedge clk);
    modelStep(w, r, f);
    #1;
    checkOutput(tag);
    bus.we = 1'b0;
    bus.re = 1'b0;
  endtask

  function automatic can_frame_t randFrame(input logic [10:0] id, input logic [3:0] dlc);
    return make_frame(id, dlc, {$urandom, $urandom});
  endfunction

  task automatic writeFrame(input logic [10:0] id, input string tag);
    applyStimulus(1'b1, 1'b0, randFrame(id, 4'd8), tag);
  endtask

  task automatic readFrame(input string tag);
    applyStimulus(1'b0, 1'b1, randFrame(11'h7FF, 4'd0), tag);
  endtask

  task automatic doReset(input string tag);
    rst    = 1'b0;
    bus.we = 1'b0;
    bus.re = 1'b0;
    @(posedge clk);
    model_q.delete();
    last_tx = '0;
    #1;
    checkOutput(tag);
    expectId({tag, "_id"}, 11'h000);
    expectBit({tag, "_empty"}, bus.empty, 1'b1);
    expectBit({tag, "_start"}, bus.start_tx, 1'b0);
    rst = 1'b1;
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    can_frame_t f;
    logic [MAX_BYTES-1:0][7:0] pay;
    logic w, r;

    bus.we       = 1'b0;
    bus.re       = 1'b0;
    bus.req_id   = '0;
    bus.req_dlc  = '0;
    bus.req_data = '0;
    last_tx      = '0;

    doReset("reset");

    // Sorted order out of unsorted writes
    writeFrame(11'h300, "sort_w0");
    writeFrame(11'h500, "sort_w1");
    writeFrame(11'h400, "sort_w2");
    expectId("sort_head0", 11'h300);
    readFrame("sort_r0");
    expectId("sort_head1", 11'h400);
    readFrame("sort_r1");
    expectId("sort_head2", 11'h500);
    readFrame("sort_r2");
    expectBit("sort_empty", bus.empty, 1'b1);

    // Preemption by a lower ID
    writeFrame(11'h600, "pre_w0");
    writeFrame(11'h100, "pre_w1");
    expectId("pre_head", 11'h100);
    readFrame("pre_r0");
    expectId("pre_after", 11'h600);
    readFrame("pre_r1");

    // Capacity: fill, then a write while full is dropped
    for (int i = 1; i <= CAP; i++) writeFrame(11'(i * 16), "cap_fill");
    expectBit("cap_full", bus.full, 1'b1);
    writeFrame(11'h005, "cap_over");
    expectId("cap_head", 11'h010);

    // Concurrent read and write on a full queue
    applyStimulus(1'b1, 1'b1, randFrame(11'h001, 4'd3), "conc_full");
    expectId("conc_full_head", 11'h001);
    expectBit("conc_full_flag", bus.full, 1'b1);
    for (int i = 0; i < CAP; i++) readFrame("conc_drain");
    expectBit("conc_drained", bus.empty, 1'b1);

    // Concurrent read and write on an empty queue
    applyStimulus(1'b1, 1'b1, randFrame(11'h077, 4'd2), "conc_empty");
    expectId("conc_empty_head", 11'h077);
    readFrame("conc_empty_r");

    // Payload and DLC carried intact
    for (int i = 0; i < MAX_BYTES; i++) pay[i] = 8'(i + 8'h23);
    applyStimulus(1'b1, 1'b0, make_frame(11'h123, 4'd5, pay), "payload");
    checks++;
    assert (bus.tx_data === 64'h2A29_2827_2625_2423) else begin
      errors++;
      $error("[TB] FAIL payload_bytes: observed %h expected %h", bus.tx_data,
             64'h2A29_2827_2625_2423);
    end
    checks++;
    assert (bus.tx_dlc === 4'd5) else begin
      errors++;
      $error("[TB] FAIL payload_dlc: observed %h expected %h", bus.tx_dlc, 4'd5);
    end
    readFrame("payload_r");

    // Equal IDs leave in arrival order, including after a preemption
    applyStimulus(1'b1, 1'b0, randFrame(11'h200, 4'd1), "eq_w0");
    applyStimulus(1'b1, 1'b0, randFrame(11'h200, 4'd2), "eq_w1");
    applyStimulus(1'b1, 1'b0, randFrame(11'h050, 4'd7), "eq_pre");
    applyStimulus(1'b1, 1'b0, randFrame(11'h200, 4'd3), "eq_w2");
    for (int i = 0; i < 4; i++) readFrame("eq_r");

    // Reset with frames queued
    writeFrame(11'h2AA, "rst_w0");
    writeFrame(11'h155, "rst_w1");
    writeFrame(11'h0F0, "rst_w2");
    doReset("reset_mid");

    // Randomized traffic; small ID range makes ties and preemption common
    for (int k = 0; k < 600; k++) begin
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      if ($urandom_range(0, 3) == 0) f.id = 11'($urandom);
      else                           f.id = 11'($urandom_range(0, 15));
      f.dlc  = 4'($urandom_range(0, 8));
      f.data = {$urandom, $urandom};
      applyStimulus(w, r, f, "random");
      if (k == 300) doReset("reset_rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
